// File: rtl/hls_launch_pkg.sv
// Shared types for the Bambu kernel run controller: FSM state encoding and verdict status codes.
package hls_launch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KRST,
        START,
        WAIT,
        REPORT
    } state_t;

    localparam logic [1:0] ST_PASS    = 2'b00;
    localparam logic [1:0] ST_FAIL    = 2'b01;
    localparam logic [1:0] ST_NOCHECK = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

endpackage

// File: rtl/hls_cycle_counter.sv
// Latency counter: load-to-1, increment, saturate at all-ones, with a terminal-count flag at TIMEOUT.
module hls_cycle_counter #(
    parameter int unsigned CYCLE_W = 32,
    parameter int unsigned TIMEOUT = 200000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    output logic [CYCLE_W-1:0] count,
    output logic               tc
);

    logic [CYCLE_W-1:0] count_d;
    logic [CYCLE_W-1:0] count_q;

    always_comb begin
        // NOTE: the hold value is assigned before any condition so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = CYCLE_W'(1);
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CYCLE_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block; state updates use <= only.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == CYCLE_W'(TIMEOUT));

endmodule

// File: rtl/hls_kernel_launcher.sv
// Run controller for one Bambu kernel: reset, start pulse, wait for done or timeout,
// then hold a verdict (status, return value, latency) until the consumer accepts it.
module hls_kernel_launcher
    import hls_launch_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CYCLE_W      = 32,
    parameter int unsigned TIMEOUT      = 200000000,
    parameter int unsigned KRST_CYCLES  = 2,
    parameter bit          KRST_ACT_LOW = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_expected,
    input  logic               req_check,
    output logic               kern_reset,
    output logic               kern_start,
    input  logic               kern_done,
    input  logic [DATA_W-1:0]  kern_return,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_status,
    output logic [DATA_W-1:0]  res_return,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [15:0]        runs_done
);

    localparam int unsigned       KRST_W    = (KRST_CYCLES > 1) ? $clog2(KRST_CYCLES) : 1;
    localparam logic [KRST_W-1:0] KRST_LAST = KRST_W'(KRST_CYCLES - 1);
    localparam logic              KRST_ON   = KRST_ACT_LOW ? 1'b0 : 1'b1;

    state_t              state_d,    state_q;
    logic [KRST_W-1:0]   krst_cnt_d, krst_cnt_q;
    logic [DATA_W-1:0]   expected_d, expected_q;
    logic                check_d,    check_q;
    logic [1:0]          status_d,   status_q;
    logic [DATA_W-1:0]   return_d,   return_q;
    logic [CYCLE_W-1:0]  cycles_d,   cycles_q;
    logic [15:0]         runs_d,     runs_q;

    logic                cnt_load;
    logic                cnt_inc;
    logic [CYCLE_W-1:0]  count;
    logic                tc;

    hls_cycle_counter #(
        .CYCLE_W (CYCLE_W),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_counter (
        .clock (clock),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (count),
        .tc    (tc)
    );

    always_comb begin
        state_d    = state_q;
        krst_cnt_d = krst_cnt_q;
        expected_d = expected_q;
        check_d    = check_q;
        status_d   = status_q;
        return_d   = return_q;
        cycles_d   = cycles_q;
        runs_d     = runs_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    expected_d = req_expected;
                    check_d    = req_check;
                    krst_cnt_d = '0;
                    state_d    = KRST;
                end
            end
            KRST: begin
                // The counter is loaded on the way out so it already reads 1 during START.
                if (krst_cnt_q == KRST_LAST) begin
                    cnt_load = 1'b1;
                    state_d  = START;
                end else begin
                    krst_cnt_d = krst_cnt_q + KRST_W'(1);
                end
            end
            START, WAIT: begin
                if (kern_done) begin
                    return_d = kern_return;
                    cycles_d = count;
                    if (!check_q) begin
                        status_d = ST_NOCHECK;
                    end else if (kern_return == expected_q) begin
                        status_d = ST_PASS;
                    end else begin
                        status_d = ST_FAIL;
                    end
                    state_d = REPORT;
                end else if (tc) begin
                    return_d = '0;
                    cycles_d = count;
                    status_d = ST_TIMEOUT;
                    state_d  = REPORT;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = WAIT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    runs_d  = runs_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            krst_cnt_q <= '0;
            expected_q <= '0;
            check_q    <= 1'b0;
            status_q   <= ST_PASS;
            return_q   <= '0;
            cycles_q   <= '0;
            runs_q     <= '0;
        end else begin
            state_q    <= state_d;
            krst_cnt_q <= krst_cnt_d;
            expected_q <= expected_d;
            check_q    <= check_d;
            status_q   <= status_d;
            return_q   <= return_d;
            cycles_q   <= cycles_d;
            runs_q     <= runs_d;
        end
    end

    // Kernel runs only in START/WAIT; every other state (including REPORT) holds it in reset.
    assign kern_reset = ((state_q == START) || (state_q == WAIT)) ? ~KRST_ON : KRST_ON;
    assign kern_start = (state_q == START);
    assign req_ready  = (state_q == IDLE);
    assign res_valid  = (state_q == REPORT);
    assign res_status = status_q;
    assign res_return = return_q;
    assign res_cycles = cycles_q;
    assign runs_done  = runs_q;

endmodule

// File: tb/tb_hls_kernel_launcher.sv
// Self-checking bench for hls_kernel_launcher: behavioural kernel model, randomized runs and a
// reference verdict derived from the run rules (start-to-done latency, check flag, timeout bound).
module tb_hls_kernel_launcher;

    localparam int DATA_W      = 32;
    localparam int CYCLE_W     = 32;
    localparam int TIMEOUT     = 100;
    localparam int KRST_CYCLES = 2;

    logic               clock;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [DATA_W-1:0]  req_expected;
    logic               req_check;
    logic               kern_reset;
    logic               kern_start;
    logic               kern_done;
    logic [DATA_W-1:0]  kern_return;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_status;
    logic [DATA_W-1:0]  res_return;
    logic [CYCLE_W-1:0] res_cycles;
    logic [15:0]        runs_done;

    int checks   = 0;
    int failures = 0;
    logic [15:0] runs_expected = '0;

    int          model_delay = -1;
    logic [31:0] model_ret   = '0;
    int          mcnt        = 0;
    bit          armed       = 1'b0;

    hls_kernel_launcher #(
        .DATA_W       (DATA_W),
        .CYCLE_W      (CYCLE_W),
        .TIMEOUT      (TIMEOUT),
        .KRST_CYCLES  (KRST_CYCLES),
        .KRST_ACT_LOW (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_expected (req_expected),
        .req_check    (req_check),
        .kern_reset   (kern_reset),
        .kern_start   (kern_start),
        .kern_done    (kern_done),
        .kern_return  (kern_return),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_status   (res_status),
        .res_return   (res_return),
        .res_cycles   (res_cycles),
        .runs_done    (runs_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Kernel model: done pulses model_delay cycles after the start pulse (never if negative);
    // the return bus carries noise whenever done is low.
    always @(negedge clock) begin
        if (kern_start === 1'b1) begin
            armed = 1'b1;
            mcnt  = 0;
        end
        if (armed && model_delay >= 0 && mcnt == model_delay) begin
            kern_done   = 1'b1;
            kern_return = model_ret;
            armed       = 1'b0;
        end else begin
            kern_done   = 1'b0;
            kern_return = $urandom;
            if (armed) mcnt++;
        end
    end

    // Reference verdict: latency is start cycle to done cycle inclusive; a run that would need more
    // than TIMEOUT cycles is reported as a timeout of exactly TIMEOUT cycles.
    task automatic ref_result(input logic [31:0] exp, input bit chk, input int delay,
                              input logic [31:0] ret, output logic [1:0] st,
                              output logic [31:0] rr, output logic [31:0] rc);
        if (delay < 0 || delay + 1 > TIMEOUT) begin
            st = 2'b11;
            rr = '0;
            rc = TIMEOUT;
        end else begin
            rc = delay + 1;
            rr = ret;
            if (!chk)            st = 2'b10;
            else if (ret == exp) st = 2'b00;
            else                 st = 2'b01;
        end
    endtask

    // Issues one request from IDLE and returns at the negedge where res_valid is first seen.
    // lat: accept cycle to start cycle; width: start pulse length; vlat: start cycle to res_valid.
    task automatic do_run(input logic [31:0] exp, input bit chk, input int delay,
                          input logic [31:0] ret, output bit got, output int lat,
                          output int width, output int vlat, output bit krst_bad);
        int cyc;
        int start_cyc;
        got = 1'b0; lat = 0; width = 0; vlat = 0; krst_bad = 1'b0;
        model_delay  = delay;
        model_ret    = ret;
        req_expected = exp;
        req_check    = chk;
        req_valid    = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 1;
        while (kern_start !== 1'b1 && cyc < 20) begin
            if (kern_reset !== 1'b0) krst_bad = 1'b1;
            @(negedge clock);
            cyc++;
        end
        if (kern_start !== 1'b1) return;
        lat       = cyc;
        start_cyc = cyc;
        while (kern_start === 1'b1 && width < 10) begin
            width++;
            if (kern_reset !== 1'b1) krst_bad = 1'b1;
            @(negedge clock);
            cyc++;
        end
        while (res_valid !== 1'b1 && cyc - start_cyc < TIMEOUT + 20) begin
            if (kern_reset !== 1'b1) krst_bad = 1'b1;
            @(negedge clock);
            cyc++;
        end
        if (res_valid !== 1'b1) return;
        if (kern_reset !== 1'b0) krst_bad = 1'b1;
        got  = 1'b1;
        vlat = cyc - start_cyc;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        runs_expected = runs_expected + 16'd1;
    endtask

    task automatic test_reset();
        logic [CYCLE_W+DATA_W+21:0] obs;
        logic [CYCLE_W+DATA_W+21:0] req;
        reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        req_expected = '0; req_check = 1'b0;
        repeat (3) @(negedge clock);
        obs = {req_ready, kern_start, kern_reset, res_valid, res_status, res_return, res_cycles, runs_done};
        req = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 16'd0};
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs, req);
        end
        reset = 1'b0;
        runs_expected = '0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || kern_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_release req_ready=%b kern_reset=%b want 1/0", req_ready, kern_reset);
        end
    endtask

    task automatic test_pass();
        bit got, kb; int lat, w, vl;
        logic [1:0] st; logic [31:0] rr, rc;
        ref_result(32'd42, 1'b1, 10, 32'd42, st, rr, rc);
        do_run(32'd42, 1'b1, 10, 32'd42, got, lat, w, vl, kb);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL pass_got_verdict got=0 want=1");
        end
        checks++;
        if (lat != KRST_CYCLES + 1 || w != 1) begin
            failures++;
            $display("FAIL pass_start lat=%0d width=%0d want %0d/1", lat, w, KRST_CYCLES + 1);
        end
        checks++;
        if (vl != int'(rc) || kb) begin
            failures++;
            $display("FAIL pass_timing vlat=%0d krst_bad=%0b want %0d/0", vl, kb, rc);
        end
        checks++;
        if (res_status !== st || res_return !== rr || res_cycles !== rc) begin
            failures++;
            $display("FAIL pass_verdict got=%b/%0d/%0d want=%b/%0d/%0d",
                     res_status, res_return, res_cycles, st, rr, rc);
        end
        accept();
        checks++;
        if (runs_done !== runs_expected || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL pass_accept runs=%0d valid=%b ready=%b want %0d/0/1",
                     runs_done, res_valid, req_ready, runs_expected);
        end
    endtask

    task automatic test_fail();
        bit got, kb; int lat, w, vl, d;
        logic [1:0] st; logic [31:0] rr, rc;
        d = $urandom_range(1, 20);
        ref_result(32'd42, 1'b1, d, 32'd41, st, rr, rc);
        do_run(32'd42, 1'b1, d, 32'd41, got, lat, w, vl, kb);
        checks++;
        if (!got || res_status !== st || res_return !== rr || res_cycles !== rc) begin
            failures++;
            $display("FAIL fail_verdict got=%0b %b/%0d/%0d want=%b/%0d/%0d",
                     got, res_status, res_return, res_cycles, st, rr, rc);
        end
        accept();
    endtask

    task automatic test_nocheck_backpressure();
        bit got, kb, bad; int lat, w, vl, d;
        logic [1:0] st; logic [31:0] rr, rc, ret;
        d   = $urandom_range(2, 30);
        ret = $urandom;
        ref_result(32'd42, 1'b0, d, ret, st, rr, rc);
        do_run(32'd42, 1'b0, d, ret, got, lat, w, vl, kb);
        checks++;
        if (!got || res_status !== st || res_return !== rr || res_cycles !== rc) begin
            failures++;
            $display("FAIL nocheck_verdict got=%0b %b/%0d/%0d want=%b/%0d/%0d",
                     got, res_status, res_return, res_cycles, st, rr, rc);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_status !== st ||
                res_return !== rr || res_cycles !== rc || runs_done !== runs_expected) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL backpressure_hold got=unstable want=stable");
        end
        accept();
        checks++;
        if (runs_done !== runs_expected) begin
            failures++;
            $display("FAIL backpressure_count runs=%0d want=%0d", runs_done, runs_expected);
        end
        @(negedge clock);
        checks++;
        if (runs_done !== runs_expected || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_once runs=%0d valid=%b want %0d/0", runs_done, res_valid, runs_expected);
        end
    endtask

    task automatic test_timeout();
        int delays [3] = '{-1, TIMEOUT - 1, TIMEOUT};
        bit got, kb; int lat, w, vl;
        logic [1:0] st; logic [31:0] rr, rc, exp;
        foreach (delays[k]) begin
            exp = $urandom;
            ref_result(exp, 1'b1, delays[k], exp, st, rr, rc);
            do_run(exp, 1'b1, delays[k], exp, got, lat, w, vl, kb);
            checks++;
            if (!got || vl != int'(rc) || kb) begin
                failures++;
                $display("FAIL timeout_timing delay=%0d got=%0b vlat=%0d krst_bad=%0b want vlat=%0d",
                         delays[k], got, vl, kb, rc);
            end
            checks++;
            if (res_status !== st || res_return !== rr || res_cycles !== rc) begin
                failures++;
                $display("FAIL timeout_verdict delay=%0d got=%b/%0d/%0d want=%b/%0d/%0d",
                         delays[k], res_status, res_return, res_cycles, st, rr, rc);
            end
            accept();
        end
    endtask

    task automatic test_done_in_start();
        bit got, kb; int lat, w, vl;
        logic [1:0] st; logic [31:0] rr, rc;
        ref_result(32'h1234, 1'b1, 0, 32'h1234, st, rr, rc);
        do_run(32'h1234, 1'b1, 0, 32'h1234, got, lat, w, vl, kb);
        checks++;
        if (!got || w != 1 || vl != 1 || res_cycles !== rc || res_status !== st || res_return !== rr) begin
            failures++;
            $display("FAIL done_in_start got=%0b width=%0d vlat=%0d %b/%0h/%0d want 1/1/1 %b/%0h/%0d",
                     got, w, vl, res_status, res_return, res_cycles, st, rr, rc);
        end
        accept();
    endtask

    task automatic test_random();
        bit got, kb, chk; int lat, w, vl, d, bp;
        logic [1:0] st; logic [31:0] rr, rc, exp, ret;
        for (int n = 0; n < 25; n++) begin
            exp = $urandom;
            chk = 1'($urandom_range(0, 1));
            d   = $urandom_range(0, 110);
            ret = ($urandom_range(0, 1) == 1) ? exp : $urandom;
            bp  = $urandom_range(0, 3);
            ref_result(exp, chk, d, ret, st, rr, rc);
            do_run(exp, chk, d, ret, got, lat, w, vl, kb);
            repeat (bp) @(negedge clock);
            checks++;
            if (!got || lat != KRST_CYCLES + 1 || w != 1 || vl != int'(rc) || kb ||
                res_status !== st || res_return !== rr || res_cycles !== rc) begin
                failures++;
                $display("FAIL random_%0d d=%0d chk=%0b got=%0b lat=%0d w=%0d vlat=%0d kb=%0b %b/%0h/%0d want %b/%0h/%0d",
                         n, d, chk, got, lat, w, vl, kb, res_status, res_return, res_cycles, st, rr, rc);
            end
            accept();
            checks++;
            if (runs_done !== runs_expected) begin
                failures++;
                $display("FAIL random_runs_%0d runs=%0d want=%0d", n, runs_done, runs_expected);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit got, kb, seen; int lat, w, vl, guard;
        logic [1:0] st; logic [31:0] rr, rc, exp;
        model_delay  = -1;
        req_expected = 32'd7;
        req_check    = 1'b1;
        req_valid    = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        guard = 0;
        while (kern_start !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        repeat (5) @(negedge clock);
        checks++;
        if (kern_reset !== 1'b1 || kern_start !== 1'b0) begin
            failures++;
            $display("FAIL midrun_in_wait kern_reset=%b kern_start=%b want 1/0", kern_reset, kern_start);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (kern_reset !== 1'b0 || res_valid !== 1'b0 || runs_done !== 16'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset kern_reset=%b valid=%b runs=%0d ready=%b want 0/0/0/1",
                     kern_reset, res_valid, runs_done, req_ready);
        end
        reset = 1'b0;
        runs_expected = '0;
        seen = 1'b0;
        repeat (TIMEOUT + 10) begin
            @(negedge clock);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midrun_silent got=verdict want=none");
        end
        exp = $urandom;
        ref_result(exp, 1'b1, 5, exp, st, rr, rc);
        do_run(exp, 1'b1, 5, exp, got, lat, w, vl, kb);
        checks++;
        if (!got || res_status !== st || res_return !== rr || res_cycles !== rc) begin
            failures++;
            $display("FAIL midrun_fresh got=%0b %b/%0h/%0d want=%b/%0h/%0d",
                     got, res_status, res_return, res_cycles, st, rr, rc);
        end
        accept();
        checks++;
        if (runs_done !== runs_expected) begin
            failures++;
            $display("FAIL midrun_runs runs=%0d want=%0d", runs_done, runs_expected);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        req_expected = '0; req_check = 1'b0;
        kern_done = 1'b0; kern_return = '0;
        test_reset();
        test_pass();
        test_fail();
        test_nocheck_backpressure();
        test_timeout();
        test_done_in_start();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
